// File: rtl/req_arbiter4.sv
// Four-requester arbiter with registered one-hot grant, bounded hold time and timeout pulse.
// Define ARB_ROUND_ROBIN_EN for a rotating priority pointer; otherwise lowest index wins.
module req_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD = 8'(MAX_HOLD);

   state_t     state, state_n;
   logic [1:0] owner, owner_n;
   logic [7:0] cnt, cnt_n;
   logic [1:0] ptr, ptr_n;
   logic       timeout_n;
   logic [3:0] cand;
   logic [1:0] winner;

   // First set bit of r, scanning upward from p with wrap-around.
   function automatic logic [1:0] scan(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] sel;
      logic       found;
      sel   = p;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   assign cand = req;
`else
   // While the timeout pulse is high, owner still names the requester that just expired.
   always_comb begin
      cand = req;
      if (timeout && ((req & ~(4'b0001 << owner)) != 4'b0000))
         cand[owner] = 1'b0;
   end
`endif

   assign winner = scan(cand, ptr);

   always_comb begin
      state_n   = state;
      owner_n   = owner;
      cnt_n     = cnt;
      ptr_n     = ptr;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_n = GRANT;
               owner_n = winner;
               cnt_n   = 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_n   = winner + 2'd1;
`endif
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               state_n = IDLE;
            end else if (cnt >= HOLD) begin
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 2'd0;
         cnt      <= 8'd0;
         ptr      <= 2'd0;
         grant    <= 4'b0000;
         grant_id <= 2'd0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         cnt      <= cnt_n;
         ptr      <= ptr_n;
         grant    <= (state_n == GRANT) ? (4'b0001 << owner_n) : 4'b0000;
         grant_id <= (state_n == GRANT) ? owner_n : 2'd0;
         busy     <= (state_n == GRANT);
         timeout  <= timeout_n;
      end
   end

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: two instances (MAX_HOLD 2 and 1) against a cycle model plus directed vectors.
module tb_req_arbiter4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt [2];
   logic [1:0] gid [2];
   logic       bsy [2];
   logic       tmo [2];

   int checks = 0;
   int errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // Model state: owner index or -1, hold count, pointer, last expired requester, timeout pulse.
   int m_own  [2];
   int m_cnt  [2];
   int m_ptr  [2];
   int m_last [2];
   bit m_to   [2];

   int seq_a [13];
   int seq_b [13];

   req_arbiter4 #(.MAX_HOLD(2)) u_arb2 (
      .clk(clk), .reset(reset), .req(req),
      .grant(gnt[0]), .grant_id(gid[0]), .busy(bsy[0]), .timeout(tmo[0])
   );

   req_arbiter4 #(.MAX_HOLD(1)) u_arb1 (
      .clk(clk), .reset(reset), .req(req),
      .grant(gnt[1]), .grant_id(gid[1]), .busy(bsy[1]), .timeout(tmo[1])
   );

   always #5 clk = ~clk;

   function automatic int hold_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int pick(input logic [3:0] r, input int p, input bit excl, input int last);
      logic [3:0] r2;
      int         idx;
      r2 = r;
      if (excl && ((r & ~(4'b0001 << last)) != 4'b0000))
         r2[last] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = (p + i) % 4;
         if (r2[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [7:0] exp_vec(input int id, input bit to);
      logic [7:0] v;
      if (id < 0) begin
         v = {7'b0000000, to};
      end else begin
         v[7:4] = 4'b0001 << id;
         v[3:2] = 2'(id);
         v[1]   = 1'b1;
         v[0]   = to;
      end
      return v;
   endfunction

   function automatic logic [7:0] got_vec(input int k);
      return {gnt[k], gid[k], bsy[k], tmo[k]};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            m_own[k]  <= -1;
            m_cnt[k]  <= 0;
            m_ptr[k]  <= 0;
            m_last[k] <= 0;
            m_to[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_own[k] < 0) begin
               m_to[k] <= 1'b0;
               if (req != 4'b0000) begin
                  m_own[k] <= pick(req, m_ptr[k], !RR && m_to[k], m_last[k]);
                  m_cnt[k] <= 1;
                  if (RR) m_ptr[k] <= (pick(req, m_ptr[k], 1'b0, 0) + 1) % 4;
               end
            end else if (!req[m_own[k]]) begin
               m_own[k] <= -1;
               m_to[k]  <= 1'b0;
            end else if (m_cnt[k] == hold_of(k)) begin
               m_last[k] <= m_own[k];
               m_own[k]  <= -1;
               m_to[k]   <= 1'b1;
            end else begin
               m_cnt[k] <= m_cnt[k] + 1;
               m_to[k]  <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_vec(k) !== exp_vec(m_own[k], m_to[k])) begin
            errors++;
            $display("FAIL model_cmp inst%0d t=%0t: got %h expected %h",
                     k, $time, got_vec(k), exp_vec(m_own[k], m_to[k]));
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [7:0] exp);
      checks++;
      if (got_vec(k) !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %h expected %h", nm, k, got_vec(k), exp);
      end
   endtask

   task automatic cyc(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("reset_pulse", 0, exp_vec(-1, 1'b0));
      reset = 1'b0;
   endtask

   task automatic run_seq(input string nm, input logic [3:0] r, input int n, input int which);
      int id;
      for (int i = 0; i < n; i++) begin
         cyc(r);
         id = (which == 0) ? seq_a[i] : seq_b[i];
         chk(nm, 0, (id < 0) ? exp_vec(-1, 1'b1) : exp_vec(id, 1'b0));
      end
   endtask

   initial begin
      reset = 1'b0;
      req   = 4'b0000;
      if (RR) seq_a = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};
      else    seq_a = '{0, 0, -1, 1, 1, -1, 0, 0, -1, 1, 1, -1, 0};
      seq_b = '{1, 1, -1, 3, 3, -1, 1, 1, 0, 0, 0, 0, 0};
      #1 reset = 1'b1;
      #11;
      chk("reset_state", 0, exp_vec(-1, 1'b0));
      chk("reset_state", 1, exp_vec(-1, 1'b0));
      reset = 1'b0;

      // single requester, released by dropping req
      cyc(4'b0100); chk("single_grant", 0, exp_vec(2, 1'b0));
      cyc(4'b0100); chk("single_hold", 0, exp_vec(2, 1'b0));
                    chk("hold1_timeout", 1, exp_vec(-1, 1'b1));
      cyc(4'b0000); chk("single_release", 0, exp_vec(-1, 1'b0));

      // held request expires, idles one cycle, is regranted
      cyc(4'b0001); chk("to_grant1", 0, exp_vec(0, 1'b0));
      cyc(4'b0001); chk("to_grant2", 0, exp_vec(0, 1'b0));
                    chk("hold1_pulse", 1, exp_vec(-1, 1'b1));
      cyc(4'b0001); chk("to_pulse", 0, exp_vec(-1, 1'b1));
                    chk("hold1_regrant", 1, exp_vec(0, 1'b0));
      cyc(4'b0001); chk("to_regrant", 0, exp_vec(0, 1'b0));
      cyc(4'b0000); chk("to_release", 0, exp_vec(-1, 1'b0));

      pulse_reset();
      run_seq("all_req_seq", 4'b1111, 13, 0);
      cyc(4'b0000);
      pulse_reset();
      run_seq("req_1010_seq", 4'b1010, 8, 1);
      cyc(4'b1010); chk("req_1010_pulse", 0, exp_vec(-1, 1'b1));
      cyc(4'b0010); chk("regrant_alone", 0, exp_vec(1, 1'b0));
      cyc(4'b0000); chk("alone_release", 0, exp_vec(-1, 1'b0));

      // asynchronous reset while requester 3 owns the grant
      cyc(4'b1000); chk("owner3_grant", 0, exp_vec(3, 1'b0));
      reset = 1'b1;
      req   = 4'b1001;
      #1;
      chk("async_reset", 0, exp_vec(-1, 1'b0));
      chk("async_reset", 1, exp_vec(-1, 1'b0));
      #1 reset = 1'b0;
      cyc(4'b1001); chk("post_reset", 0, exp_vec(0, 1'b0));
                    chk("post_reset", 1, exp_vec(0, 1'b0));
      cyc(4'b0000);

      // non-owner request noise around owner 2
      cyc(4'b0100); chk("noise_grant", 0, exp_vec(2, 1'b0));
      cyc(4'b1101); chk("noise_hold", 0, exp_vec(2, 1'b0));
      cyc(4'b0101); chk("noise_expire", 0, exp_vec(-1, 1'b1));
      cyc(4'b0100); chk("noise_regrant", 0, exp_vec(2, 1'b0));
      cyc(4'b1001); chk("noise_drop", 0, exp_vec(-1, 1'b0));
      cyc(4'b0000);
      cyc(4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/req_arbiter4.md
REQ_ARBITER4 -- requirements
Module: req_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, max consecutive cycles one requester may hold a grant (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request per requester; bit i = requester i.
REQ-005 grant  output  4  one-hot grant, registered; all-zero when no owner.
REQ-006 grant_id  output  2  binary index of current owner; 0 when no owner.
REQ-007 busy  output  1  high while any grant bit is high.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no owner), GRANT (one owner).
REQ-010 In IDLE with req!=0, the block SHALL select a winner and enter GRANT; grant/grant_id/busy SHALL assert on the next edge (1-cycle latency).
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with all outputs 0.
REQ-012 Winner selection SHALL scan requesters starting at priority pointer ptr, ascending mod 4; first set bit wins.
REQ-013 The block SHALL load a hold counter (8 bits) with 1 on GRANT entry.
REQ-014 In GRANT with req[owner]=1 and counter<MAX_HOLD, the block SHALL stay in GRANT and increment counter.
REQ-015 In GRANT with req[owner]=0, the block SHALL return to IDLE; grant SHALL drop on the next edge; timeout SHALL stay 0.
REQ-016 In GRANT with req[owner]=1 and counter==MAX_HOLD, the block SHALL return to IDLE and pulse timeout high for exactly the first IDLE cycle; grant is therefore high for exactly MAX_HOLD cycles.
REQ-017 Every release SHALL cost one IDLE cycle before any new grant (no back-to-back handover).
REQ-018 Changes on req bits of non-owners SHALL NOT affect the current grant.
REQ-019 grant SHALL never have more than one bit set; grant_id SHALL always equal the index of the set bit.
REQ-020 MAX_HOLD=1 SHALL give one-cycle grants, each followed by timeout if the owner still requests.

Reset
REQ-021 On reset assertion, the block SHALL immediately (asynchronously) force state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, counter=0, ptr=0.
REQ-022 Reset mid-grant SHALL discard the owner; the first arbitration after deassertion SHALL use ptr=0.
REQ-023 Requests held across reset deassertion SHALL be granted one cycle after the first clock edge with reset low.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the pointer policy.
REQ-025 With ARB_ROUND_ROBIN_EN defined: on each grant to requester i, ptr SHALL update to (i+1) mod 4.
REQ-026 Without ARB_ROUND_ROBIN_EN: ptr SHALL be fixed at 0 (lowest index wins), except that the arbitration immediately following a timeout SHALL exclude the timed-out requester if any other req bit is set.
REQ-027 All other behaviour (latency, counter, timeout, reset) SHALL be identical in both builds.

Verification
REQ-028 Single request: req=4'b0100 from cycle 0 -> grant=4'b0100, grant_id=2, busy=1 at cycle 1; req=0 at cycle 3 -> grant=0 at cycle 4, timeout=0.
REQ-029 Timeout, MAX_HOLD=3: req=4'b0001 held -> grant=4'b0001 for cycles 1-3, timeout=1 and grant=0 at cycle 4, regrant at cycle 5.
REQ-030 Round-robin (macro defined), MAX_HOLD=2: req=4'b1111 held -> grant_id sequence 0,0,-,1,1,-,2,2,-,3,3,-,0 ('-' = IDLE cycle).
REQ-031 Fixed priority (macro undefined), MAX_HOLD=2: req=4'b1010 held -> grant_id 1,1,-,3,3,-,1,1; req=4'b0010 alone after timeout -> requester 1 regranted.
REQ-032 Async reset: assert reset mid-cycle while grant=4'b1000 -> grant=0, busy=0 before the next clock edge; after release with req=4'b1001 -> grant_id=0.
REQ-033 Non-owner noise: owner 2 granted, toggle req[0], req[3] every cycle -> grant stays 4'b0100 until req[2] drops or MAX_HOLD expires.
